mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameters: WORD, default 8, data width; ADDRESSL, default 5, address width; LENGTH, default 32, word count (2^ADDRESSL).
REQ-002 SHALL have ports, one per line, clock and reset first:
  clk  input  1  single clock; all state updates on rising edge
  rst  input  1  reset, synchronous, active-low
  start  input  1  request pulse; sampled only in IDLE
  mode  input  1  0 = copy src->dst; 1 = fill dst with pattern
  srcAddr  input  ADDRESSL  first source address (copy mode)
  dstAddr  input  ADDRESSL  first destination address
  count  input  ADDRESSL+1  words to transfer, 0..LENGTH
  pattern  input  WORD  fill value (fill mode)
  busy  output  1  high in READ and WRITE
  done  output  1  one-cycle completion pulse
  memAddress  output  ADDRESSL  memory address
  memWriteData  output  WORD  memory write data
  memReadData  input  WORD  memory read data, combinational from memAddress while memRead high
  memRead  output  1  read strobe
  memWrite  output  1  write strobe

Function
REQ-003 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-004 IDLE: start=1 SHALL latch srcAddr, dstAddr, count, mode, pattern; next state is DONE if count=0, WRITE if mode=1, otherwise READ.
REQ-005 count values above LENGTH SHALL saturate to LENGTH.
REQ-006 READ SHALL drive memRead=1 and memAddress=curSrc, capture memReadData into the data register at the clock edge, then go to WRITE.
REQ-007 WRITE SHALL drive memWrite=1, memAddress=curDst, and memWriteData equal to the data register (copy) or the latched pattern (fill) for exactly one cycle.
REQ-008 At the end of WRITE: curSrc and curDst SHALL increment, remaining SHALL decrement; next state is DONE if remaining was 1, otherwise READ (copy) or WRITE (fill).
REQ-009 Address increments SHALL wrap modulo 2^ADDRESSL (address 31 -> 0 at default).
REQ-010 DONE SHALL assert done=1 for one cycle, then go to IDLE.
REQ-011 memRead and memWrite SHALL never be high in the same cycle; both SHALL be 0 in IDLE and DONE.
REQ-012 memAddress and memWriteData SHALL be 0 whenever the corresponding strobe is low.
REQ-013 Latency from the start-accept edge to done high SHALL be 2*count+1 cycles in copy mode, count+1 cycles in fill mode, and 1 cycle for count=0.
REQ-014 start while not in IDLE (including DONE) SHALL be ignored and not queued.
REQ-015 Copy SHALL proceed in ascending address order; overlapping src/dst ranges SHALL produce the ascending-order result, with no overlap correction.

Reset
REQ-016 rst=0 at a clock edge SHALL force IDLE and clear busy, done, memRead, memWrite, memAddress, memWriteData, and all address, count and data registers to 0.
REQ-017 Reset mid-transfer SHALL abort with no further memory strobes; words already written stay written; no done pulse.

Structure
REQ-018 A shared package SHALL hold the state encoding (2-bit: IDLE, READ, WRITE, DONE) and the WORD/ADDRESSL/LENGTH defaults.
REQ-019 One sub-module, mem_copy_counter, SHALL hold the curSrc/curDst wrapping incrementers and the remaining down-counter, with load, step and last outputs.

Verification
REQ-020 Copy: mem[2..4]={0x11,0x22,0x33}, start, mode=0, src=2, dst=10, count=3 -> mem[10..12]={0x11,0x22,0x33}, done 7 cycles after accept, busy high for 6 cycles.
REQ-021 Fill: mode=1, dst=30, count=4, pattern=0xA5 -> mem[30], mem[31], mem[0], mem[1]=0xA5 (wrap), done 5 cycles after accept, memRead never high.
REQ-022 count=0 -> no strobes, done 1 cycle after accept; count=40 -> exactly 32 writes.
REQ-023 start pulsed every cycle during a copy with count=2 -> exactly 2 reads and 2 writes, a single done, no restart.
REQ-024 rst=0 during the second WRITE of a count=5 copy -> strobes low next cycle; only dst words 0 and 1 modified; no done pulse; next start operates normally.

Source files
------------

// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy/fill engine: state encoding and
// default geometry.
package mem_copy_engine_pkg;

  localparam int WORD_DEF     = 8;
  localparam int ADDRESSL_DEF = 5;
  localparam int LENGTH_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_copy_counter.sv
// Address walkers and word down-counter for the copy engine. Addresses wrap
// naturally at the address width; last flags the final word of a transfer.
module mem_copy_counter
  import mem_copy_engine_pkg::*;
#(
  parameter int ADDRESSL = ADDRESSL_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [ADDRESSL-1:0] src_init,
  input  logic [ADDRESSL-1:0] dst_init,
  input  logic [ADDRESSL:0]   count_init,
  output logic [ADDRESSL-1:0] cur_src,
  output logic [ADDRESSL-1:0] cur_dst,
  output logic                last
);

  logic [ADDRESSL:0] remaining;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_src   <= src_init;
      cur_dst   <= dst_init;
      remaining <= count_init;
    end else if (step) begin
      cur_src   <= cur_src + ADDRESSL'(1);
      cur_dst   <= cur_dst + ADDRESSL'(1);
      remaining <= remaining - (ADDRESSL + 1)'(1);
    end
  end

  assign last = (remaining == (ADDRESSL + 1)'(1));

endmodule

// File: rtl/mem_copy_engine.sv
// Single-port memory copy / pattern-fill engine. One word moves per READ+WRITE
// pair in copy mode, per WRITE in fill mode; done pulses once per request.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int WORD     = WORD_DEF,
  parameter int ADDRESSL = ADDRESSL_DEF,
  parameter int LENGTH   = LENGTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDRESSL-1:0] srcAddr,
  input  logic [ADDRESSL-1:0] dstAddr,
  input  logic [ADDRESSL:0]   count,
  input  logic [WORD-1:0]     pattern,
  output logic                busy,
  output logic                done,
  output logic [ADDRESSL-1:0] memAddress,
  output logic [WORD-1:0]     memWriteData,
  input  logic [WORD-1:0]     memReadData,
  output logic                memRead,
  output logic                memWrite
);

  localparam logic [ADDRESSL:0] COUNT_MAX = (ADDRESSL + 1)'(LENGTH);

  state_t              state;
  state_t              state_next;
  logic                mode_q;
  logic [WORD-1:0]     pattern_q;
  logic [WORD-1:0]     data_q;
  logic                load;
  logic                step;
  logic                last;
  logic [ADDRESSL-1:0] cur_src;
  logic [ADDRESSL-1:0] cur_dst;
  logic [ADDRESSL:0]   count_sat;

  // Requests larger than the memory move every word exactly once.
  assign count_sat = (count > COUNT_MAX) ? COUNT_MAX : count;

  mem_copy_counter #(
    .ADDRESSL (ADDRESSL)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .src_init   (srcAddr),
    .dst_init   (dstAddr),
    .count_init (count_sat),
    .cur_src    (cur_src),
    .cur_dst    (cur_dst),
    .last       (last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      pattern_q <= '0;
      data_q    <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        mode_q    <= mode;
        pattern_q <= pattern;
      end
      if (state == READ) data_q <= memReadData;
    end
  end

  // Strobes are decoded from state only, so address/data stay zero whenever
  // their strobe is low and a reset drops them on the very next cycle.
  always_comb begin
    state_next   = state;
    load         = 1'b0;
    step         = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    memAddress   = '0;
    memWriteData = '0;
    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (count_sat == '0) state_next = DONE;
          else if (mode)       state_next = WRITE;
          else                 state_next = READ;
        end
      end
      READ: begin
        busy       = 1'b1;
        memRead    = 1'b1;
        memAddress = cur_src;
        state_next = WRITE;
      end
      WRITE: begin
        busy         = 1'b1;
        memWrite     = 1'b1;
        memAddress   = cur_dst;
        memWriteData = mode_q ? pattern_q : data_q;
        step         = 1'b1;
        if (last)        state_next = DONE;
        else if (mode_q) state_next = WRITE;
        else             state_next = READ;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomised scoreboard bench for mem_copy_engine: a word-level reference model
// predicts read addresses, write address/data pairs and done timing.
module tb_mem_copy_engine;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int W  = AW + DW;
  localparam int N  = 32;

  typedef struct {
    int cyc;
    int busy_n;
  } done_exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic          start = 1'b0;
  logic          mode  = 1'b0;
  logic [AW-1:0] srcAddr = '0;
  logic [AW-1:0] dstAddr = '0;
  logic [AW:0]   count = '0;
  logic [DW-1:0] pattern = '0;
  logic          busy, done, memRead, memWrite;
  logic [AW-1:0] memAddress;
  logic [DW-1:0] memWriteData, memReadData;

  mem_copy_engine #(
    .WORD     (DW),
    .ADDRESSL (AW),
    .LENGTH   (N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode         (mode),
    .srcAddr      (srcAddr),
    .dstAddr      (dstAddr),
    .count        (count),
    .pattern      (pattern),
    .busy         (busy),
    .done         (done),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memReadData  (memReadData),
    .memRead      (memRead),
    .memWrite     (memWrite)
  );

  // memory attached to the engine, and the model's view of it
  logic [DW-1:0] mem     [N];
  logic [DW-1:0] ref_mem [N];

  always @(posedge clk) if (memWrite) mem[memAddress] <= memWriteData;
  always_comb memReadData = memRead ? mem[memAddress] : '0;

  // scoreboard
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] rd_q[$];
  done_exp_t     done_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: word i goes from src+i to dst+i (mod N) in ascending
  // order; done is sampled by the edge accept+latency.
  task automatic model_xfer(input logic m, input int src, input int dst, input int cnt,
                            input logic [DW-1:0] pat, input int writes_lim, input bit expect_done);
    int n;
    int nw;
    int lat;
    logic [DW-1:0] d;
    n   = (cnt > N) ? N : cnt;
    nw  = (writes_lim < n) ? writes_lim : n;
    for (int i = 0; i < nw; i++) begin
      if (!m) rd_q.push_back(AW'((src + i) % N));
      d = m ? pat : ref_mem[(src + i) % N];
      exp_q.push_back({AW'((dst + i) % N), d});
      ref_mem[(dst + i) % N] = d;
    end
    lat = (n == 0) ? 1 : (m ? n + 1 : 2 * n + 1);
    if (expect_done) done_q.push_back('{cyc: cyc + lat, busy_n: (m ? n : 2 * n)});
  endtask

  // driver
  task automatic run_xfer(input logic m, input int src, input int dst, input int cnt,
                          input logic [DW-1:0] pat, input bit hold);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    mode    = m;
    srcAddr = AW'(src);
    dstAddr = AW'(dst);
    count   = (AW + 1)'(cnt);
    pattern = pat;
    start   = 1'b1;
    model_xfer(m, src, dst, cnt, pat, N + 1, 1'b1);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      start = hold;
      if (done) seen = 1'b1;
    end
    if (hold) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic poke(input int a, input logic [DW-1:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  // monitor
  int            busy_cnt = 0;
  logic [W-1:0]  mon_w;
  done_exp_t     mon_d;
  logic          rules_ok;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    else if (!done) busy_cnt = 0;

    rules_ok = !(memRead && memWrite)
             && (memRead || memWrite || memAddress == '0)
             && (memWrite || memWriteData == '0)
             && (busy || !(memRead || memWrite));
    check("strobe_rules", 32'(rules_ok), 32'd1);

    if (memRead) begin
      if (rd_q.size() == 0) check("unexpected_read", 32'(memAddress), 32'hffff_ffff);
      else check("read_addr", 32'(memAddress), 32'(rd_q.pop_front()));
    end
    if (memWrite) begin
      if (exp_q.size() == 0) check("unexpected_write", 32'({memAddress, memWriteData}), 32'hffff_ffff);
      else begin
        mon_w = exp_q.pop_front();
        check("write_addr_data", 32'({memAddress, memWriteData}), 32'(mon_w));
      end
    end
    if (done) begin
      if (done_q.size() == 0) check("unexpected_done", 32'(cyc), 32'hffff_ffff);
      else begin
        mon_d = done_q.pop_front();
        check("done_cycle", 32'(cyc), 32'(mon_d.cyc));
        check("busy_cycles", 32'(busy_cnt), 32'(mon_d.busy_n));
      end
    end
  end

  // main sequence
  initial begin
    for (int i = 0; i < N; i++) poke(i, DW'($urandom_range(0, 255)));
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({busy, done, memRead, memWrite, memAddress, memWriteData}), 32'd0);
    rst = 1'b1;

    // directed copy
    poke(2, 8'h11); poke(3, 8'h22); poke(4, 8'h33);
    run_xfer(1'b0, 2, 10, 3, 8'h00, 1'b0);
    check("copy_word0", 32'(mem[10]), 32'h11);
    check("copy_word1", 32'(mem[11]), 32'h22);
    check("copy_word2", 32'(mem[12]), 32'h33);

    // directed fill with address wrap
    run_xfer(1'b1, 0, 30, 4, 8'hA5, 1'b0);
    check("fill_30", 32'(mem[30]), 32'hA5);
    check("fill_31", 32'(mem[31]), 32'hA5);
    check("fill_0",  32'(mem[0]),  32'hA5);
    check("fill_1",  32'(mem[1]),  32'hA5);

    // zero-length and oversized requests
    run_xfer(1'b0, 5, 7, 0, 8'h00, 1'b0);
    run_xfer(1'b1, 0, 3, 40, 8'h3C, 1'b0);
    run_xfer(1'b0, 9, 3, 40, 8'h00, 1'b0);

    // start held high for the whole transfer
    run_xfer(1'b0, 8, 16, 2, 8'h00, 1'b1);

    // reset during the second WRITE of a five-word copy
    @(posedge clk); #1;
    mode = 1'b0; srcAddr = AW'(20); dstAddr = AW'(4); count = (AW + 1)'(5); start = 1'b1;
    model_xfer(1'b0, 20, 4, 5, 8'h00, 2, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_in_write", 32'({memWrite, memAddress}), 32'({1'b1, 5'd5}));
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_strobes", 32'({memRead, memWrite, busy, done}), 32'd0);
    rst = 1'b1;
    for (int i = 4; i < 9; i++) check("abort_dst", 32'(mem[i]), 32'(ref_mem[i]));

    // randomised transfers
    repeat (14) begin
      run_xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
               int'($urandom_range(0, N - 1)), int'($urandom_range(0, 40)),
               DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    #1;
    check("reads_left",  32'(rd_q.size()),   32'd0);
    check("writes_left", 32'(exp_q.size()),  32'd0);
    check("dones_left",  32'(done_q.size()), 32'd0);
    for (int i = 0; i < N; i++) check("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
